// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for an RV32I subset: sequences fetch/decode/execute/memory/writeback
// over a shared memory and drives datapath mux selects, write strobes and the ALU operation.
module multicycle_control_unit #(
  parameter int WIDTH      = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_ins,
  input  logic                  i_mem_ready,
  input  logic                  i_eq,
  input  logic                  i_lt,
  input  logic                  i_ltu,
  output logic                  o_pc_write,
  output logic                  o_ir_write,
  output logic                  o_adr_src,
  output logic                  o_mem_write,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [2:0]            o_imm_src,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_reg_write,
  output logic                  o_retire,
  output logic                  o_illegal,
  output logic [3:0]            o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND    = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR     = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU   = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS_B = ALU_CTRL_W'(10);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_taken;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;
  logic       w_unused;

  assign w_opcode = i_ins[6:0];
  assign w_funct3 = i_ins[14:12];
  assign w_f7b5   = i_ins[30];
  assign w_unused = ^{i_ins[WIDTH-1:31], i_ins[29:15], i_ins[11:7]};

  // funct3 decode shared by R and I types; the two flags pick SUB and SRA respectively
  function automatic logic [ALU_CTRL_W-1:0] f_alu_op(input logic [2:0] f3,
                                                     input logic       alt_sub,
                                                     input logic       alt_sra);
    case (f3)
      3'b000:  f_alu_op = alt_sub ? ALU_SUB : ALU_ADD;
      3'b001:  f_alu_op = ALU_SLL;
      3'b010:  f_alu_op = ALU_SLT;
      3'b011:  f_alu_op = ALU_SLTU;
      3'b100:  f_alu_op = ALU_XOR;
      3'b101:  f_alu_op = alt_sra ? ALU_SRA : ALU_SRL;
      3'b110:  f_alu_op = ALU_OR;
      3'b111:  f_alu_op = ALU_AND;
      default: f_alu_op = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = i_eq;
      3'b001:  w_taken = ~i_eq;
      3'b100:  w_taken = i_lt;
      3'b101:  w_taken = ~i_lt;
      3'b110:  w_taken = i_ltu;
      3'b111:  w_taken = ~i_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  // Reset leaves every output at its zero default, so no strobe can fire in a reset cycle
  always_comb begin
    w_next       = r_state;
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_result_src = 2'd0;
    o_alu_src_a  = 2'd0;
    o_alu_src_b  = 2'd0;
    o_imm_src    = IMM_I;
    o_alu_ctrl   = ALU_ADD;
    o_reg_write  = 1'b0;
    o_retire     = 1'b0;
    if (i_rst) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_alu_src_b  = 2'd2;
          o_result_src = 2'd2;
          o_ir_write   = i_mem_ready;
          o_pc_write   = i_mem_ready;
          if (i_mem_ready) w_next = S_DECODE;
        end
        S_DECODE: begin
          o_alu_src_a = 2'd1;
          o_alu_src_b = 2'd1;
          o_imm_src   = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
          case (w_opcode)
            OP_LOAD, OP_STORE: w_next = S_MEMADR;
            OP_RTYPE:          w_next = S_EXECR;
            OP_ITYPE, OP_LUI:  w_next = S_EXECI;
            OP_BRANCH:         w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            default:           w_next = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          o_alu_src_a = 2'd2;
          o_alu_src_b = 2'd1;
          if (w_opcode == OP_STORE) begin
            o_imm_src = IMM_S;
            w_next    = S_MEMWRITE;
          end else begin
            o_imm_src = IMM_I;
            w_next    = S_MEMREAD;
          end
        end
        S_MEMREAD: begin
          o_adr_src = 1'b1;
          if (i_mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          o_result_src = 2'd1;
          o_reg_write  = 1'b1;
          o_retire     = 1'b1;
          w_next       = S_FETCH;
        end
        S_MEMWRITE: begin
          o_adr_src   = 1'b1;
          o_mem_write = 1'b1;
          if (i_mem_ready) begin
            o_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end
        S_EXECR: begin
          o_alu_src_a = 2'd2;
          o_alu_ctrl  = f_alu_op(w_funct3, w_f7b5, w_f7b5);
          w_next      = S_ALUWB;
        end
        S_EXECI: begin
          o_alu_src_a = 2'd2;
          o_alu_src_b = 2'd1;
          if (w_opcode == OP_LUI) begin
            o_imm_src  = IMM_U;
            o_alu_ctrl = ALU_PASS_B;
          end else begin
            o_alu_ctrl = f_alu_op(w_funct3, 1'b0, w_f7b5);
          end
          w_next = S_ALUWB;
        end
        S_ALUWB: begin
          o_reg_write = 1'b1;
          o_retire    = 1'b1;
          w_next      = S_FETCH;
        end
        S_BRANCH: begin
          o_alu_src_a = 2'd2;
          o_alu_ctrl  = ALU_SUB;
          // funct3 010/011 are not branches; treat them as illegal rather than retiring
          if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
            w_next = S_TRAP;
          end else begin
            o_retire   = 1'b1;
            o_pc_write = w_taken;
            w_next     = S_FETCH;
          end
        end
        S_JAL: begin
          o_alu_src_a = 2'd1;
          o_alu_src_b = 2'd2;
          o_pc_write  = 1'b1;
          w_next      = S_ALUWB;
        end
        S_TRAP:  w_next = S_TRAP;
        default: w_next = S_FETCH;
      endcase
    end
  end

  assign o_illegal = r_illegal & ~i_rst;
  assign o_state   = i_rst ? S_FETCH : r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-level bench: each instruction is expanded into its expected cycle
// sequence and the DUT outputs are compared every cycle, plus literal checks of key cycles.
module tb_multicycle_control_unit;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9,
                 P_JAL = 10, P_TRAP = 11;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, adr, memw;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       regw, ret, ill;
  } out_t;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        mr, eq, lt, ltu;
    out_t        exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst, mr, eq, lt, ltu;
  logic [31:0] ins;
  logic pcw, irw, adr, memw, regw, ret, ill;
  logic [1:0] rs, a, b;
  logic [2:0] imm;
  logic [3:0] alu, st;

  cyc_t expQ[$];
  out_t snaps[$];
  int   nChecks = 0;
  int   nFail   = 0;
  int   applied = 0;
  logic modelIll = 1'b0;
  int   aluBase[8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  always #5 clk = ~clk;

  multicycle_control_unit #(.WIDTH(32), .ALU_CTRL_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_ins(ins), .i_mem_ready(mr), .i_eq(eq), .i_lt(lt), .i_ltu(ltu),
    .o_pc_write(pcw), .o_ir_write(irw), .o_adr_src(adr), .o_mem_write(memw),
    .o_result_src(rs), .o_alu_src_a(a), .o_alu_src_b(b), .o_imm_src(imm), .o_alu_ctrl(alu),
    .o_reg_write(regw), .o_retire(ret), .o_illegal(ill), .o_state(st)
  );

  // Expected outputs for one cycle of a given phase of an instruction
  function automatic out_t model(int ph, logic [31:0] insV, logic m, logic e, logic l,
                                 logic lu, logic il);
    out_t o = '0;
    logic [6:0] op = insV[6:0];
    int f3 = int'(insV[14:12]);
    logic alt = insV[30];
    logic taken = 1'b0;
    o.st  = 4'(ph);
    o.ill = il;
    case (f3)
      0: taken = e;   1: taken = !e;
      4: taken = l;   5: taken = !l;
      6: taken = lu;  7: taken = !lu;
      default: taken = 1'b0;
    endcase
    case (ph)
      P_FETCH:    begin o.b = 2'd2; o.rs = 2'd2; o.irw = m; o.pcw = m; end
      P_DECODE:   begin o.a = 2'd1; o.b = 2'd1; o.imm = (op == 7'h6F) ? 3'd3 : 3'd2; end
      P_MEMADR:   begin o.a = 2'd2; o.b = 2'd1; o.imm = (op == 7'h23) ? 3'd1 : 3'd0; end
      P_MEMREAD:  o.adr = 1'b1;
      P_MEMWB:    begin o.rs = 2'd1; o.regw = 1'b1; o.ret = 1'b1; end
      P_MEMWRITE: begin o.adr = 1'b1; o.memw = 1'b1; o.ret = m; end
      P_EXECR: begin
        o.a = 2'd2;
        o.alu = (f3 == 0 && alt) ? 4'd1 : (f3 == 5 && alt) ? 4'd9 : 4'(aluBase[f3]);
      end
      P_EXECI: begin
        o.a = 2'd2; o.b = 2'd1;
        if (op == 7'h37) begin o.imm = 3'd4; o.alu = 4'd10; end
        else o.alu = (f3 == 5 && alt) ? 4'd9 : 4'(aluBase[f3]);
      end
      P_ALUWB:  begin o.regw = 1'b1; o.ret = 1'b1; end
      P_BRANCH: begin
        o.a = 2'd2; o.alu = 4'd1;
        if (f3 != 2 && f3 != 3) begin o.ret = 1'b1; o.pcw = taken; end
      end
      P_JAL:    begin o.a = 2'd1; o.b = 2'd2; o.pcw = 1'b1; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic applyStimulus(input cyc_t c);
    @(posedge clk);
    #1;
    rst = c.rst; ins = c.ins; mr = c.mr; eq = c.eq; lt = c.lt; ltu = c.ltu;
    expQ.push_back(c);
    applied++;
  endtask

  task automatic resetCycles(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b1; c.ins = ins; c.mr = 1'($urandom);
      c.eq = 1'($urandom); c.lt = 1'($urandom); c.ltu = 1'($urandom);
      c.exp = '0;
      modelIll = 1'b0;
      applyStimulus(c);
    end
  endtask

  task automatic runInstr(input logic [31:0] insV, input int fStall, input int mStall,
                          input int eqSel, input int trapLen, input int cutAt,
                          input int rstLen, output int startIdx);
    int   phs[$];
    logic mrs[$];
    cyc_t c;
    int   n;
    int   f3 = int'(insV[14:12]);
    startIdx = applied;
    for (int i = 0; i < fStall; i++) begin phs.push_back(P_FETCH); mrs.push_back(1'b0); end
    phs.push_back(P_FETCH); mrs.push_back(1'b1);
    phs.push_back(P_DECODE); mrs.push_back(1'($urandom));
    case (insV[6:0])
      7'h03: begin
        phs.push_back(P_MEMADR); mrs.push_back(1'($urandom));
        for (int i = 0; i < mStall; i++) begin phs.push_back(P_MEMREAD); mrs.push_back(1'b0); end
        phs.push_back(P_MEMREAD); mrs.push_back(1'b1);
        phs.push_back(P_MEMWB); mrs.push_back(1'($urandom));
      end
      7'h23: begin
        phs.push_back(P_MEMADR); mrs.push_back(1'($urandom));
        for (int i = 0; i < mStall; i++) begin phs.push_back(P_MEMWRITE); mrs.push_back(1'b0); end
        phs.push_back(P_MEMWRITE); mrs.push_back(1'b1);
      end
      7'h33: begin
        phs.push_back(P_EXECR); mrs.push_back(1'($urandom));
        phs.push_back(P_ALUWB); mrs.push_back(1'($urandom));
      end
      7'h13, 7'h37: begin
        phs.push_back(P_EXECI); mrs.push_back(1'($urandom));
        phs.push_back(P_ALUWB); mrs.push_back(1'($urandom));
      end
      7'h63: begin
        phs.push_back(P_BRANCH); mrs.push_back(1'($urandom));
        if (f3 == 2 || f3 == 3)
          for (int i = 0; i < trapLen; i++) begin phs.push_back(P_TRAP); mrs.push_back(1'($urandom)); end
      end
      7'h6F: begin
        phs.push_back(P_JAL); mrs.push_back(1'($urandom));
        phs.push_back(P_ALUWB); mrs.push_back(1'($urandom));
      end
      default:
        for (int i = 0; i < trapLen; i++) begin phs.push_back(P_TRAP); mrs.push_back(1'($urandom)); end
    endcase
    n = (cutAt >= 0 && cutAt < phs.size()) ? cutAt : phs.size();
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b0; c.ins = insV; c.mr = mrs[i];
      c.eq  = (eqSel == 2) ? 1'($urandom) : 1'(eqSel);
      c.lt  = 1'($urandom); c.ltu = 1'($urandom);
      if (phs[i] == P_TRAP) modelIll = 1'b1;
      c.exp = model(phs[i], insV, c.mr, c.eq, c.lt, c.ltu, modelIll);
      applyStimulus(c);
    end
    if (n < phs.size() || phs[phs.size()-1] == P_TRAP) resetCycles(rstLen < 1 ? 1 : rstLen);
  endtask

  task automatic checkOutput(input string nm, input int got, input int req);
    nChecks++;
    if (got != req) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  always @(negedge clk) begin : compare
    cyc_t e;
    out_t g;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      g.st = st; g.pcw = pcw; g.irw = irw; g.adr = adr; g.memw = memw;
      g.rs = rs; g.a = a; g.b = b; g.imm = imm; g.alu = alu;
      g.regw = regw; g.ret = ret; g.ill = ill;
      nChecks++;
      if (g !== e.exp) begin
        nFail++;
        $display("[TB] FAIL cycle%0d outputs: got st=%0d vec=%h, required st=%0d vec=%h (ins=%h rst=%b mr=%b)",
                 snaps.size(), g.st, g, e.exp.st, e.exp, e.ins, e.rst, e.mr);
      end
      snaps.push_back(g);
    end
  end

  function automatic int strobes(out_t o);
    return int'(o.pcw) + int'(o.irw) + int'(o.memw) + int'(o.regw) + int'(o.ret);
  endfunction

  initial begin
    int s, cnt, cnt2, k, cls;
    logic [31:0] r;
    logic [6:0]  op;
    rst = 1'b1; ins = 32'h0; mr = 1'b1; eq = 1'b0; lt = 1'b0; ltu = 1'b0;

    resetCycles(2);
    runInstr(32'h00500093, 0, 0, 2, 0, -1, 0, s);
    @(negedge clk); #1;
    checkOutput("rst_state", int'(snaps[0].st), 0);
    checkOutput("rst_strobes", strobes(snaps[1]), 0);
    checkOutput("post_rst_ir_write", int'(snaps[s].irw), 1);
    checkOutput("post_rst_pc_write", int'(snaps[s].pcw), 1);
    checkOutput("addi_execi_state", int'(snaps[s+2].st), 7);
    checkOutput("addi_imm_src", int'(snaps[s+2].imm), 0);
    checkOutput("addi_alu_ctrl", int'(snaps[s+2].alu), 0);
    checkOutput("addi_aluwb_reg_write", int'(snaps[s+3].regw), 1);
    cnt = 0;
    for (int i = s; i < s + 4; i++) cnt += int'(snaps[i].ret);
    checkOutput("addi_retire_once", cnt, 1);
    checkOutput("addi_retire_cycle4", int'(snaps[s+3].ret), 1);

    runInstr(32'h0000a103, 1, 3, 2, 0, -1, 0, s);
    @(negedge clk); #1;
    cnt = 0; cnt2 = 0;
    for (int i = s; i < s + 9; i++) begin
      cnt  += (snaps[i].st == 4'd3) ? 1 : 0;
      cnt2 += int'(snaps[i].regw);
    end
    checkOutput("lw_memread_cycles", cnt, 4);
    checkOutput("lw_reg_write_count", cnt2, 1);
    checkOutput("lw_memwb_reg_write", int'(snaps[s+8].regw), 1);
    checkOutput("lw_memwb_result_src", int'(snaps[s+8].rs), 1);

    runInstr(32'h00209463, 0, 0, 0, 0, -1, 0, s);
    @(negedge clk); #1;
    checkOutput("bne_ne_pc_write", int'(snaps[s+2].pcw), 1);
    checkOutput("bne_ne_retire", int'(snaps[s+2].ret), 1);
    runInstr(32'h00209463, 0, 0, 1, 0, -1, 0, s);
    @(negedge clk); #1;
    checkOutput("bne_eq_pc_write", int'(snaps[s+2].pcw), 0);
    checkOutput("bne_eq_retire", int'(snaps[s+2].ret), 1);

    runInstr(32'h008000EF, 0, 0, 2, 0, -1, 0, s);
    @(negedge clk); #1;
    checkOutput("jal_decode_imm_src", int'(snaps[s+1].imm), 3);
    checkOutput("jal_pc_write", int'(snaps[s+2].pcw), 1);
    checkOutput("jal_aluwb_reg_write", int'(snaps[s+3].regw), 1);
    checkOutput("jal_aluwb_result_src", int'(snaps[s+3].rs), 0);

    runInstr(32'h0000007F, 0, 0, 2, 10, -1, 1, s);
    @(negedge clk); #1;
    cnt = 0; cnt2 = 0;
    for (int i = s + 2; i < s + 12; i++) begin
      cnt  += int'(snaps[i].ill);
      cnt2 += strobes(snaps[i]);
    end
    checkOutput("trap_illegal_cycles", cnt, 10);
    checkOutput("trap_strobes", cnt2, 0);

    runInstr(32'h0020a023, 0, 3, 2, 0, 4, 1, s);
    @(negedge clk); #1;
    checkOutput("sw_stall_mem_write", int'(snaps[s+3].memw), 1);
    checkOutput("sw_rst_mem_write", int'(snaps[s+4].memw), 0);
    runInstr(32'h00500093, 0, 0, 2, 0, -1, 0, s);
    @(negedge clk); #1;
    checkOutput("after_rst_state", int'(snaps[s].st), 0);
    checkOutput("after_rst_illegal", int'(snaps[s].ill), 0);

    for (int n = 0; n < 300; n++) begin
      r   = $urandom;
      cls = $urandom_range(0, 15);
      case (cls)
        0, 1:           op = 7'h33;
        2, 3, 14, 15:   op = 7'h13;
        4:              op = 7'h37;
        5, 6:           op = 7'h03;
        7, 8:           op = 7'h23;
        9, 10, 11:      op = 7'h63;
        12:             op = 7'h6F;
        default: begin
          op = 7'($urandom);
          while (op == 7'h03 || op == 7'h23 || op == 7'h33 || op == 7'h13 ||
                 op == 7'h37 || op == 7'h63 || op == 7'h6F) op = 7'($urandom);
        end
      endcase
      r[6:0] = op;
      k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      runInstr(r, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2,
               int'($urandom_range(1, 4)), k, int'($urandom_range(1, 2)), s);
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle FSM control unit; successor to the single-cycle addi/bne decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared instruction/data memory with a ready handshake.
- Decodes RV32I subset: R-type ALU, I-type ALU, lw, sw, beq/bne/blt/bge/bltu/bgeu, jal, lui.
- Drives datapath muxes, register/PC/IR write strobes and ALU op; flags illegal opcodes.

Parameters:
- WIDTH, 32, instruction width (decode uses bits [31:0]).
- ALU_CTRL_W, 4, alu_ctrl width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ins  in  WIDTH  instruction from IR, stable from DECODE until return to FETCH
- mem_ready  in  1  memory access completes this cycle
- eq  in  1  rs1==rs2, valid in BRANCH
- lt  in  1  signed rs1<rs2, valid in BRANCH
- ltu  in  1  unsigned rs1<rs2, valid in BRANCH
- pc_write  out  1  PC load enable
- ir_write  out  1  IR / old_PC load enable
- adr_src  out  1  memory address: 0=PC, 1=result
- mem_write  out  1  memory write strobe
- result_src  out  2  0=alu_out reg, 1=mem data, 2=alu result
- alu_src_a  out  2  0=PC, 1=old_PC, 2=rs1
- alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
- imm_src  out  3  0=I, 1=S, 2=B, 3=J, 4=U
- alu_ctrl  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse on final cycle of each completed instruction
- illegal  out  1  sticky illegal-instruction flag
- state  out  4  current state, for debug and bench

Behaviour:
- Reset: synchronous; next state FETCH; illegal cleared. While rst=1, all strobes (pc_write, ir_write, mem_write, reg_write, retire) forced 0. All other outputs 0.
- Reset mid-operation (any state) aborts the instruction; no write strobe asserts in the reset cycle.
- Outputs are combinational from state and ins. Unlisted outputs are 0.
- FETCH: adr_src=0, a=0, b=2, ADD, result_src=2. ir_write=pc_write=mem_ready. Holds while !mem_ready; else goes to DECODE.
- DECODE: a=1, b=1, ADD. imm_src=J for jal, else B.
  - Next state: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011/0110111 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> TRAP.
- MEMADR: a=2, b=1, ADD, imm_src=I (lw) or S (sw). Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adr_src=1, result_src=0. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=1, reg_write=1, retire=1. Next: FETCH.
- MEMWRITE: adr_src=1, result_src=0, mem_write=1 every cycle until mem_ready. Then retire=1 and go to FETCH.
- EXECR: a=2, b=0. alu_ctrl by funct3: 000 ADD (SUB if funct7[5]), 111 AND, 110 OR, 100 XOR, 010 SLT, 011 SLTU, 001 SLL, 101 SRL (SRA if funct7[5]). Next: ALUWB.
- EXECI: a=2, b=1. For lui: imm_src=U, PASS_B. Otherwise imm_src=I, alu_ctrl as EXECR except funct7[5] only selects SRA for funct3=101 (addi never SUB). Next: ALUWB.
- ALUWB: result_src=0, reg_write=1, retire=1. Next: FETCH.
- BRANCH: a=2, b=0, SUB, result_src=0, retire=1. pc_write=taken. Next: FETCH.
  - taken by funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 -> TRAP instead, no pc_write.
- JAL: a=1, b=2, ADD, result_src=0, pc_write=1 (PC<=target held in alu_out). Next: ALUWB (writes old_PC+4 to rd).
- TRAP: illegal=1 (sticky); no strobes; remains in TRAP until rst.
- Write strobes never assert in the same cycle as rst.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- rst held 2 cycles, mem_ready=1 -> state=FETCH, all strobes 0 during rst; first post-reset cycle ir_write=pc_write=1.
- addi x1,x0,5 (0x00500093), mem_ready=1 -> FETCH, DECODE, EXECI (imm_src=0, ADD), ALUWB reg_write=1, retire; 4 cycles.
- lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, reg_write only in MEMWB with result_src=1.
- bne (funct3=001): eq=0 -> pc_write=1 in BRANCH; eq=1 -> pc_write=0; both retire after 3 cycles.
- jal x1,8 -> DECODE imm_src=3; JAL pc_write=1; ALUWB reg_write=1, result_src=0.
- opcode 0x7F -> TRAP, illegal=1 persists 10 cycles with no strobes. Assert rst during a sw MEMWRITE stall -> mem_write=0 that cycle, FETCH next, illegal=0.
